// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: opcodes, FSM states,
// ALU-control opcodes, datapath mux selects and the control word layout.
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG_B   = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_ct_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decode. Only FETCH and MEMWR look at
// mem_ready, so their writes/completion coincide with the memory handshake.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_ct_op = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Branch target is computed speculatively before the opcode is known.
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_ct_op = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ct_op = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG_B;
                ctrl.alu_ct_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG_B;
                ctrl.alu_ct_op     = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ct_op = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, next-state sequencing,
// sticky illegal-opcode trap and branch-gated PC enable.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_ct_op,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDIU:     state_d = S_ADDIEX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      state_d = S_MEMRD;
                else if (opcode == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_TRAP;
            end
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset forces every output low immediately, independent of the clock.
    assign ctrl_out = rst ? ctrl_raw : '0;

    assign pc_write      = ctrl_out.pc_write;
    assign pc_write_cond = ctrl_out.pc_write_cond;
    assign pc_source     = ctrl_out.pc_source;
    assign i_or_d        = ctrl_out.i_or_d;
    assign mem_read      = ctrl_out.mem_read;
    assign mem_write     = ctrl_out.mem_write;
    assign ir_write      = ctrl_out.ir_write;
    assign reg_dst       = ctrl_out.reg_dst;
    assign reg_write     = ctrl_out.reg_write;
    assign mem_to_reg    = ctrl_out.mem_to_reg;
    assign alu_src_a     = ctrl_out.alu_src_a;
    assign alu_src_b     = ctrl_out.alu_src_b;
    assign alu_ct_op     = ctrl_out.alu_ct_op;
    assign instr_done    = ctrl_out.instr_done;

    assign pc_en      = ctrl_out.pc_write | (ctrl_out.pc_write_cond & zero);
    assign illegal_op = rst & illegal_q;
    assign state      = rst ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: each cycle's expected output word is queued
// from a table model of the control outputs and checked mid-cycle.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a;
    logic       instr_done, illegal_op;
    logic [1:0] pc_source, alu_src_b, alu_ct_op;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_ill = 1'b0;
    logic [22:0] exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    mc_main_ctrl #(.STATE_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_ct_op     (alu_ct_op),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    // Expected outputs for a given state, written straight from the state table.
    function automatic logic [22:0] model(input logic [3:0] st, input logic mr,
                                          input logic z, input logic ill, input logic r);
        logic pe, pw, pwc, iod, mrd, mwr, irw, rd, rw, m2r, sa, done;
        logic [1:0] ps, sb, op;
        {pe, pw, pwc, iod, mrd, mwr, irw, rd, rw, m2r, sa, done} = '0;
        ps = 2'b00; sb = 2'b00; op = 2'b00;
        case (st)
            4'd0:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pw = mr; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iod = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            4'd5:  begin mwr = 1'b1; iod = 1'b1; done = mr; end
            4'd6:  begin sa = 1'b1; op = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
            4'd8:  begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; done = 1'b1; end
            4'd9:  begin pw = 1'b1; ps = 2'b10; done = 1'b1; end
            4'd10: begin sa = 1'b1; sb = 2'b10; end
            4'd11: begin rw = 1'b1; done = 1'b1; end
            default: ;
        endcase
        pe = pw | (pwc & z);
        if (!r) return '0;
        return {pe, pw, pwc, ps, iod, mrd, mwr, irw, rd, rw, m2r, sa, sb, op, done, ill, st};
    endfunction

    task automatic cyc(input string tag, input logic [3:0] st, input logic mr,
                       input logic z, input logic r);
        logic [22:0] e, o;
        string t;
        logic ill;
        rst = r; mem_ready = mr; zero = z;
        ill = r & (exp_ill | (st == 4'd12));
        exp_q.push_back(model(st, mr, z, ill, r));
        tag_q.push_back(tag);
        exp_ill = ill;
        #3;
        o = {pc_en, pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_ct_op,
             instr_done, illegal_op, state};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b100011;

        cyc("reset0", 4'd0, 1'b1, 1'b0, 1'b0);
        cyc("reset1", 4'd0, 1'b1, 1'b0, 1'b0);

        opcode = 6'b100011;
        cyc("lw_fetch",  4'd0, 1'b1, 1'b0, 1'b1);
        cyc("lw_decode", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("lw_memadr", 4'd2, 1'b1, 1'b0, 1'b1);
        cyc("lw_memrd",  4'd3, 1'b1, 1'b0, 1'b1);
        cyc("lw_memwb",  4'd4, 1'b1, 1'b0, 1'b1);
        $display("txn lw (no stall)");

        cyc("lws_fetch_stall0", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc("lws_fetch_stall1", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc("lws_fetch_ready",  4'd0, 1'b1, 1'b0, 1'b1);
        cyc("lws_decode",       4'd1, 1'b1, 1'b0, 1'b1);
        cyc("lws_memadr",       4'd2, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc("lws_memrd_stall", 4'd3, 1'b0, 1'b0, 1'b1);
        cyc("lws_memrd_ready",  4'd3, 1'b1, 1'b0, 1'b1);
        cyc("lws_memwb",        4'd4, 1'b1, 1'b0, 1'b1);
        $display("txn lw (stalled, 10 cycles)");

        opcode = 6'b000000;
        cyc("r_fetch",  4'd0, 1'b1, 1'b0, 1'b1);
        cyc("r_decode", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("r_exec",   4'd6, 1'b1, 1'b0, 1'b1);
        cyc("r_aluwb",  4'd7, 1'b1, 1'b0, 1'b1);
        $display("txn R-type");

        opcode = 6'b000100;
        cyc("beq1_fetch",  4'd0, 1'b1, 1'b1, 1'b1);
        cyc("beq1_decode", 4'd1, 1'b1, 1'b1, 1'b1);
        cyc("beq1_branch", 4'd8, 1'b1, 1'b1, 1'b1);
        $display("txn beq taken");
        cyc("beq0_fetch",  4'd0, 1'b1, 1'b0, 1'b1);
        cyc("beq0_decode", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("beq0_branch", 4'd8, 1'b1, 1'b0, 1'b1);
        $display("txn beq not taken");

        opcode = 6'b000010;
        cyc("j_fetch",  4'd0, 1'b1, 1'b0, 1'b1);
        cyc("j_decode", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("j_jump",   4'd9, 1'b1, 1'b0, 1'b1);
        $display("txn j");

        opcode = 6'b101011;
        cyc("sw_fetch",       4'd0, 1'b1, 1'b0, 1'b1);
        cyc("sw_decode",      4'd1, 1'b1, 1'b0, 1'b1);
        cyc("sw_memadr",      4'd2, 1'b1, 1'b0, 1'b1);
        cyc("sw_memwr_stall", 4'd5, 1'b0, 1'b0, 1'b1);
        cyc("sw_memwr_ready", 4'd5, 1'b1, 1'b0, 1'b1);
        $display("txn sw");

        opcode = 6'b001001;
        cyc("addiu_fetch",  4'd0,  1'b1, 1'b0, 1'b1);
        cyc("addiu_decode", 4'd1,  1'b1, 1'b0, 1'b1);
        cyc("addiu_ex",     4'd10, 1'b1, 1'b0, 1'b1);
        cyc("addiu_wb",     4'd11, 1'b1, 1'b0, 1'b1);
        $display("txn addiu");

        opcode = 6'b100011;
        cyc("abort_fetch",  4'd0, 1'b1, 1'b0, 1'b1);
        cyc("abort_decode", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("abort_memadr", 4'd2, 1'b1, 1'b0, 1'b1);
        cyc("abort_rst",    4'd3, 1'b1, 1'b0, 1'b0);
        cyc("abort_after",  4'd0, 1'b0, 1'b0, 1'b1);
        cyc("abort_fetch2", 4'd0, 1'b1, 1'b0, 1'b1);
        cyc("abort_decode2", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("abort_memadr2", 4'd2, 1'b1, 1'b0, 1'b1);
        cyc("abort_memrd2",  4'd3, 1'b1, 1'b0, 1'b1);
        cyc("abort_memwb2",  4'd4, 1'b1, 1'b0, 1'b1);
        $display("txn lw aborted by reset, then lw");

        opcode = 6'b111111;
        cyc("ill_fetch",  4'd0, 1'b1, 1'b0, 1'b1);
        cyc("ill_decode", 4'd1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            cyc("ill_trap", 4'd12, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        cyc("trap_rst",   4'd12, 1'b1, 1'b0, 1'b0);
        opcode = 6'b000010;
        cyc("post_rst_fetch",  4'd0, 1'b1, 1'b0, 1'b1);
        cyc("post_rst_decode", 4'd1, 1'b1, 1'b0, 1'b1);
        cyc("post_rst_jump",   4'd9, 1'b1, 1'b0, 1'b1);
        $display("txn illegal opcode trap and reset recovery");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
